ddr_bus_turnaround_ctrl: RTL
============================

# ddr_bus_turnaround_ctrl

Parametrised DDR data-bus direction and turnaround controller, successor to the single-lane DQ/DQS enable logic. It tracks WRITE and READ commands from the command sequencer and generates per-byte-lane DQ/DQS output enables, DQS toggle enable, read capture window, system-side data request, and a command-accept flag. It sits between the command FSM and the DQ/DQS I/O cells, and enforces preamble, postamble and write-recovery spacing.

## Interface

Parameters:
- LANES, 2: number of byte lanes (DQS groups); ≥1.
- BURST_LEN, 4: burst length in beats; 2, 4 or 8. One clk cycle carries 2 beats, so a data window is BURST_LEN/2 cycles.
- WR_LAT, 1: cycles from accepted write to the write-preamble cycle; ≥1.
- RD_LAT, 2: cycles from accepted read to the read-preamble cycle (CAS latency); ≥1.
- TWR, 2: write-recovery cycles after the write postamble; ≥0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_cmd  in  1  one-cycle pulse: WRITE issued.
- rd_cmd  in  1  one-cycle pulse: READ issued.
- wr_lane_en  in  LANES  lane write mask, sampled with an accepted wr_cmd.
- data_out_rdy  in  1  system write datapath holds valid data.
- dq_oe  out  LANES  per-lane DQ output enable (1 drive, 0 input).
- dqs_oe  out  LANES  per-lane DQS output enable.
- dqs_toggle_en  out  1  DQS toggles (0 = held low while driven).
- rd_capture_en  out  1  read-data capture window.
- sys_dataio_en  out  1  request write data from system datapath.
- cmd_ok  out  1  a command presented this cycle will be accepted.
- cmd_err  out  1  one-cycle pulse: command rejected.
- wr_underrun  out  1  one-cycle pulse: data_out_rdy low while sys_dataio_en high.

## Operation

- States: IDLE, WR_WAIT, WR_PRE, WR_DATA, WR_POST, WR_REC, RD_WAIT, RD_PRE, RD_DATA, RD_POST. A single down-counter, width clog2(max(WR_LAT,RD_LAT,BURST_LEN/2,TWR)+1), times every state.
- All outputs are registered decodes of state or registered pulses. No combinational input-to-output path.
- cmd_ok = 1 only in IDLE.
- Command accepted: the command is high while cmd_ok = 1. wr_cmd moves to WR_WAIT, or directly to WR_PRE if WR_LAT = 1. rd_cmd behaves the same way for reads. An accepted write latches wr_lane_en.
- Write sequence: WR_WAIT (WR_LAT−1 cycles) → WR_PRE (1) → WR_DATA (BURST_LEN/2) → WR_POST (1) → WR_REC (TWR; skipped if 0) → IDLE.
- Read sequence: RD_WAIT (RD_LAT−1) → RD_PRE (1) → RD_DATA (BURST_LEN/2) → RD_POST (1) → IDLE.
- dqs_oe = all ones in WR_PRE, WR_DATA and WR_POST; 0 otherwise.
- dq_oe = latched lane mask in WR_DATA; 0 otherwise.
- dqs_toggle_en = 1 in WR_DATA only.
- rd_capture_en = 1 in RD_DATA only.
- Direction outputs are 0 in every read state and in IDLE.
- sys_dataio_en is high one cycle ahead of dq_oe: in WR_PRE and in every WR_DATA cycle except the last.
- wr_underrun pulses in the cycle after a cycle where sys_dataio_en = 1 and data_out_rdy = 0. The burst continues unchanged.
- Rejection: any command seen while cmd_ok = 0 is ignored, and cmd_err pulses the next cycle.
- Simultaneous commands: wr_cmd and rd_cmd high together in IDLE → the write is accepted, the read is dropped, and cmd_err pulses.
- Reset, including mid-burst: after the edge with rst = 1, the state is IDLE and cmd_ok = 1. dq_oe, dqs_oe, dqs_toggle_en, rd_capture_en, sys_dataio_en, cmd_err and wr_underrun are all 0. Commands sampled while rst = 1 are ignored with no cmd_err. The latched mask clears to 0.

## Timing

- Cycle 0 is the cycle in which the command is high. Cycle n is the n-th cycle after that.
- Write, with B = BURST_LEN/2:
  - preamble: cycle WR_LAT
  - data: cycles WR_LAT+1 … WR_LAT+B
  - postamble: cycle WR_LAT+B+1
  - recovery: the next TWR cycles
  - cmd_ok returns in cycle WR_LAT+B+2+TWR
- Read:
  - preamble: cycle RD_LAT
  - capture: cycles RD_LAT+1 … RD_LAT+B
  - postamble: cycle RD_LAT+B+1
  - cmd_ok returns in cycle RD_LAT+B+2
- Minimum read-to-write and write-to-read turnaround is set by the above. Bursts never overlap, so dq_oe and rd_capture_en are never high in the same cycle.

## Test plan

- Defaults (LANES=2, BL=4, WR_LAT=1, TWR=2), wr_cmd with wr_lane_en=2'b11 in cycle 0:
  - dqs_oe=11 in cycles 1–4
  - dq_oe=11 and dqs_toggle_en=1 in cycles 2–3
  - sys_dataio_en in cycles 1–2
  - cmd_ok=0 in cycles 1–6, back to 1 in cycle 7
- rd_cmd with RD_LAT=2, BL=8: rd_capture_en in cycles 3–6; dq_oe and dqs_oe stay 0 throughout; cmd_ok=1 in cycle 8.
- Masked write, wr_lane_en=2'b01: dq_oe=01 during the data cycles while dqs_oe=11. A wr_cmd in cycle 3 is ignored and cmd_err pulses in cycle 4.
- wr_cmd and rd_cmd together in IDLE: write timing as in the first case, no rd_capture_en, cmd_err=1 in cycle 1.
- data_out_rdy=0 in cycle 2 of a default write: wr_underrun=1 in cycle 3, and dq_oe timing is unchanged.
- rst asserted in cycle 2 of a default write: all enables 0 and cmd_ok=1 in cycle 3. A new wr_cmd in cycle 3 is accepted normally.

Source files
------------

// File: rtl/ddr_bus_turnaround_ctrl.sv
// DDR DQ/DQS direction and turnaround controller: sequences write/read bursts
// with preamble, postamble and write recovery, all outputs registered.
module ddr_bus_turnaround_ctrl #(
  parameter int LANES     = 2,
  parameter int BURST_LEN = 4,
  parameter int WR_LAT    = 1,
  parameter int RD_LAT    = 2,
  parameter int TWR       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_cmd,
  input  logic             rd_cmd,
  input  logic [LANES-1:0] wr_lane_en,
  input  logic             data_out_rdy,
  output logic [LANES-1:0] dq_oe,
  output logic [LANES-1:0] dqs_oe,
  output logic             dqs_toggle_en,
  output logic             rd_capture_en,
  output logic             sys_dataio_en,
  output logic             cmd_ok,
  output logic             cmd_err,
  output logic             wr_underrun
);

  localparam int B       = BURST_LEN / 2;
  localparam int M1      = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int M2      = (M1 > B) ? M1 : B;
  localparam int CNT_MAX = (M2 > TWR) ? M2 : TWR;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Counter loads are (duration - 1); a state exits when the counter hits zero.
  localparam logic [CW-1:0] LD_WR_WAIT = CW'((WR_LAT >= 2) ? WR_LAT - 2 : 0);
  localparam logic [CW-1:0] LD_RD_WAIT = CW'((RD_LAT >= 2) ? RD_LAT - 2 : 0);
  localparam logic [CW-1:0] LD_DATA    = CW'((B >= 1) ? B - 1 : 0);
  localparam logic [CW-1:0] LD_REC     = CW'((TWR >= 1) ? TWR - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [3:0] {
    IDLE, WR_WAIT, WR_PRE, WR_DATA, WR_POST, WR_REC,
    RD_WAIT, RD_PRE, RD_DATA, RD_POST
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [LANES-1:0] dq_oe_q, dq_oe_d;
  logic [LANES-1:0] dqs_oe_q, dqs_oe_d;
  logic             dqs_toggle_en_q, dqs_toggle_en_d;
  logic             rd_capture_en_q, rd_capture_en_d;
  logic             sys_dataio_en_q, sys_dataio_en_d;
  logic             cmd_ok_q, cmd_ok_d;
  logic             cmd_err_q, cmd_err_d;
  logic             wr_underrun_q, wr_underrun_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (wr_cmd) begin
          mask_d = wr_lane_en;
          if (WR_LAT > 1) begin
            state_d = WR_WAIT;
            cnt_d   = LD_WR_WAIT;
          end else begin
            state_d = WR_PRE;
          end
        end else if (rd_cmd) begin
          if (RD_LAT > 1) begin
            state_d = RD_WAIT;
            cnt_d   = LD_RD_WAIT;
          end else begin
            state_d = RD_PRE;
          end
        end
      end
      WR_WAIT: begin
        if (cnt_zero) state_d = WR_PRE;
        else          cnt_d   = cnt_q - CNT_ONE;
      end
      WR_PRE: begin
        state_d = WR_DATA;
        cnt_d   = LD_DATA;
      end
      WR_DATA: begin
        if (cnt_zero) state_d = WR_POST;
        else          cnt_d   = cnt_q - CNT_ONE;
      end
      WR_POST: begin
        if (TWR > 0) begin
          state_d = WR_REC;
          cnt_d   = LD_REC;
        end else begin
          state_d = IDLE;
        end
      end
      WR_REC: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt_q - CNT_ONE;
      end
      RD_WAIT: begin
        if (cnt_zero) state_d = RD_PRE;
        else          cnt_d   = cnt_q - CNT_ONE;
      end
      RD_PRE: begin
        state_d = RD_DATA;
        cnt_d   = LD_DATA;
      end
      RD_DATA: begin
        if (cnt_zero) state_d = RD_POST;
        else          cnt_d   = cnt_q - CNT_ONE;
      end
      RD_POST: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output flops decode the next state so they line up with the state register.
    dq_oe_d         = (state_d == WR_DATA) ? mask_d : '0;
    dqs_oe_d        = (state_d == WR_PRE || state_d == WR_DATA || state_d == WR_POST)
                      ? '1 : '0;
    dqs_toggle_en_d = (state_d == WR_DATA);
    rd_capture_en_d = (state_d == RD_DATA);
    sys_dataio_en_d = (state_d == WR_PRE) || (state_d == WR_DATA && cnt_d != '0);
    cmd_ok_d        = (state_d == IDLE);
    cmd_err_d       = ((wr_cmd || rd_cmd) && state_q != IDLE) ||
                      (wr_cmd && rd_cmd && state_q == IDLE);
    wr_underrun_d   = sys_dataio_en_q && !data_out_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      mask_q          <= '0;
      dq_oe_q         <= '0;
      dqs_oe_q        <= '0;
      dqs_toggle_en_q <= 1'b0;
      rd_capture_en_q <= 1'b0;
      sys_dataio_en_q <= 1'b0;
      cmd_ok_q        <= 1'b1;
      cmd_err_q       <= 1'b0;
      wr_underrun_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mask_q          <= mask_d;
      dq_oe_q         <= dq_oe_d;
      dqs_oe_q        <= dqs_oe_d;
      dqs_toggle_en_q <= dqs_toggle_en_d;
      rd_capture_en_q <= rd_capture_en_d;
      sys_dataio_en_q <= sys_dataio_en_d;
      cmd_ok_q        <= cmd_ok_d;
      cmd_err_q       <= cmd_err_d;
      wr_underrun_q   <= wr_underrun_d;
    end
  end

  assign dq_oe         = dq_oe_q;
  assign dqs_oe        = dqs_oe_q;
  assign dqs_toggle_en = dqs_toggle_en_q;
  assign rd_capture_en = rd_capture_en_q;
  assign sys_dataio_en = sys_dataio_en_q;
  assign cmd_ok        = cmd_ok_q;
  assign cmd_err       = cmd_err_q;
  assign wr_underrun   = wr_underrun_q;

endmodule
